// File: rtl/div_mul_pkg.sv
// Shared definitions for the sequential divider and shift-and-add multiplier.
// Holds the FSM state encoding and the default operand width.
package div_mul_pkg;

  localparam int DEFAULT_WIDTH = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // The unused code 2'd3 is treated as IDLE so the FSM always recovers.
  function automatic logic is_idle(input logic [1:0] st);
    return !(st == ST_RUN || st == ST_DONE);
  endfunction

endpackage

// File: rtl/shift_register_aq.sv
// {C,A,Q} right-shift register for the shift-and-add multiplier.
// Each shift step first adds M into A when Q[0] is set, then shifts the carry into A's MSB.
module shift_register_aq
  import div_mul_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift_right_enable,
  input  logic [WIDTH-1:0] load_q,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] q
);

  // {C,A}: the carry only lives within a step, so it is never stored.
  logic [WIDTH:0] sum;

  always_comb begin
    sum = {1'b0, a};
    if (q[0]) sum = {1'b0, a} + {1'b0, m};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a <= '0;
      q <= '0;
    end else if (load) begin
      a <= '0;
      q <= load_q;
    end else if (shift_right_enable) begin
      {a, q} <= {sum, q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier, one product bit per cycle.
// Optional macro ZERO_SKIP_EN: zero operands bypass RUN and complete straight away.
//
// state | meaning
// IDLE  | waiting for start; product holds the last result
// RUN   | one add/shift step per cycle, WIDTH steps
// DONE  | final cycle of the operation; done pulses on the following cycle
module shift_add_multiplier
  import div_mul_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [WIDTH-1:0] m_reg;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] q;
  logic [CW-1:0]    count;
  logic             load;
  logic             shift_en;
  logic             zero_op;
  logic [WIDTH-1:0] load_q;

`ifdef ZERO_SKIP_EN
  assign zero_op = (multiplicand == '0) || (multiplier == '0);
`else
  assign zero_op = 1'b0;
`endif

  assign load_q = zero_op ? '0 : multiplier;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:  if (count == LAST_STEP) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: begin
        state_nxt = ST_IDLE;
        if (start) state_nxt = zero_op ? ST_DONE : ST_RUN;
      end
    endcase
  end

  always_comb begin
    load     = is_idle(state) && start;
    shift_en = (state == ST_RUN);
    busy     = (state == ST_RUN) || (state == ST_DONE);
  end

  // done is registered so it lands one cycle after the final DONE state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done  <= 1'b0;
      count <= '0;
      m_reg <= '0;
    end else begin
      done <= (state == ST_DONE);
      if (load) begin
        count <= '0;
        m_reg <= multiplicand;
      end else if (shift_en) begin
        count <= count + 1'b1;
      end
    end
  end

  shift_register_aq #(.WIDTH(WIDTH)) u_aq (
    .clk                (clk),
    .rst                (rst),
    .load               (load),
    .shift_right_enable (shift_en),
    .load_q             (load_q),
    .m                  (m_reg),
    .a                  (a),
    .q                  (q)
  );

  assign product = {a, q};

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier (WIDTH=4) with a product scoreboard.
module tb_shift_add_multiplier;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [W-1:0]   mcand;
  logic [W-1:0]   mplier;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  int checks = 0;
  int errors = 0;
  logic [2*W-1:0] exp_q[$];

  always #5 clk = ~clk;

  shift_add_multiplier #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (mcand),
    .multiplier   (mplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  // Scoreboard: every done pulse pops one expected product.
  always @(negedge clk) begin : monitor
    logic [2*W-1:0] e;
    if (!rst && done) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done product=%0d (no operation pending)", product);
      end else begin
        e = exp_q.pop_front();
        if (product !== e) begin
          errors++;
          $display("FAIL product got=%0d expected=%0d", product, e);
        end
      end
    end
  end

  function automatic int exp_latency(input logic [W-1:0] m, input logic [W-1:0] q);
`ifdef ZERO_SKIP_EN
    if (m == 0 || q == 0) return 1;
`endif
    return W + 1;
  endfunction

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; mcand = '0; mplier = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b expected=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b expected=0", done); end
    checks++; if (product !== '0) begin errors++; $display("FAIL reset_product got=%0d expected=0", product); end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got=%b expected=0", busy); end
  endtask

  task automatic test_basic;
    int busy_cnt;
    int done_at;
    @(posedge clk); #1;
    mcand = 4'd13; mplier = 4'd11; start = 1'b1;
    exp_q.push_back(8'd143);
    @(posedge clk); #1;
    start = 1'b0;
    busy_cnt = busy ? 1 : 0;
    done_at = -1;
    for (int k = 1; k <= 20 && done_at < 0; k++) begin
      @(posedge clk); #1;
      mcand = 4'($urandom); mplier = 4'($urandom);
      if (busy) busy_cnt++;
      if (done) done_at = k;
    end
    checks++; if (done_at != 5) begin errors++; $display("FAIL basic_latency got=%0d expected=5", done_at); end
    checks++; if (busy_cnt != 5) begin errors++; $display("FAIL basic_busy_cycles got=%0d expected=5", busy_cnt); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (product !== 8'd143) begin errors++; $display("FAIL basic_hold got=%0d expected=143", product); end
  endtask

  task automatic test_carry;
    int done_at;
    @(posedge clk); #1;
    mcand = 4'd15; mplier = 4'd15; start = 1'b1;
    exp_q.push_back(8'hE1);
    @(posedge clk); #1;
    start = 1'b0;
    done_at = -1;
    for (int k = 1; k <= 20 && done_at < 0; k++) begin
      @(posedge clk); #1;
      if (done) done_at = k;
    end
    checks++; if (done_at != 5) begin errors++; $display("FAIL carry_latency got=%0d expected=5", done_at); end
    checks++; if (product !== 8'hE1) begin errors++; $display("FAIL carry_product got=%0d expected=225", product); end
  endtask

  task automatic test_zero;
    logic [W-1:0] ms [2] = '{4'd0, 4'd7};
    logic [W-1:0] qs [2] = '{4'd9, 4'd0};
    int done_at;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      mcand = ms[i]; mplier = qs[i]; start = 1'b1;
      exp_q.push_back('0);
      @(posedge clk); #1;
      start = 1'b0;
      done_at = -1;
      for (int k = 1; k <= 20 && done_at < 0; k++) begin
        @(posedge clk); #1;
        if (done) done_at = k;
      end
      checks++;
      if (done_at != exp_latency(ms[i], qs[i])) begin
        errors++;
        $display("FAIL zero_latency[%0d] got=%0d expected=%0d", i, done_at, exp_latency(ms[i], qs[i]));
      end
    end
  endtask

  task automatic test_ignore_start;
    int done_cnt;
    @(posedge clk); #1;
    mcand = 4'd13; mplier = 4'd11; start = 1'b1;
    exp_q.push_back(8'd143);
    @(posedge clk); #1;
    start = 1'b0;
    done_cnt = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin start = 1'b1; mcand = 4'd5; mplier = 4'd5; end
      if (k == 3) start = 1'b0;
      if (done) begin
        done_cnt++;
        checks++;
        if (k != 5) begin errors++; $display("FAIL ignore_latency got=%0d expected=5", k); end
      end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL ignore_done_count got=%0d expected=1", done_cnt); end
  endtask

  task automatic test_reset_abort;
    int done_cnt;
    int done_at;
    @(posedge clk); #1;
    mcand = 4'd9; mplier = 4'd10; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b expected=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done got=%b expected=0", done); end
    checks++; if (product !== '0) begin errors++; $display("FAIL abort_product got=%0d expected=0", product); end
    #2 rst = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
    end
    checks++; if (done_cnt != 0) begin errors++; $display("FAIL abort_no_done got=%0d expected=0", done_cnt); end
    mcand = 4'd6; mplier = 4'd7; start = 1'b1;
    exp_q.push_back(8'd42);
    @(posedge clk); #1;
    start = 1'b0;
    done_at = -1;
    for (int k = 1; k <= 20 && done_at < 0; k++) begin
      @(posedge clk); #1;
      if (done) done_at = k;
    end
    checks++; if (done_at != 5) begin errors++; $display("FAIL abort_next_latency got=%0d expected=5", done_at); end
  endtask

  task automatic test_back_to_back;
    int pulses;
    @(posedge clk); #1;
    mcand = 4'd1; mplier = 4'd1; start = 1'b1;
    repeat (3) exp_q.push_back(8'd1);
    @(posedge clk); #1;
    pulses = 0;
    for (int k = 1; k <= 17; k++) begin
      @(posedge clk); #1;
      if (k == 17) start = 1'b0;
      checks++;
      if (done !== ((k % 6) == 5)) begin
        errors++;
        $display("FAIL b2b_done edge=%0d got=%b expected=%b", k, done, ((k % 6) == 5));
      end
      if (done) pulses++;
    end
    checks++; if (pulses != 3) begin errors++; $display("FAIL b2b_pulses got=%0d expected=3", pulses); end
    repeat (8) @(posedge clk);
  endtask

  task automatic test_random;
    logic [W-1:0] m;
    logic [W-1:0] q;
    int done_at;
    for (int i = 0; i < 8; i++) begin
      m = 4'($urandom_range(0, 15));
      q = 4'($urandom_range(0, 15));
      @(posedge clk); #1;
      mcand = m; mplier = q; start = 1'b1;
      exp_q.push_back(8'(m) * 8'(q));
      @(posedge clk); #1;
      start = 1'b0;
      done_at = -1;
      for (int k = 1; k <= 20 && done_at < 0; k++) begin
        @(posedge clk); #1;
        if (done) done_at = k;
      end
      checks++;
      if (done_at != exp_latency(m, q)) begin
        errors++;
        $display("FAIL random_latency %0d*%0d got=%0d expected=%0d", m, q, done_at, exp_latency(m, q));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_zero();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    test_random();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_results got=%0d expected=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
